// File: rtl/y_receiver_if.sv
// Y-side 4-phase request/acknowledge channel between the write buffer (source)
// and y_receiver (sink).
interface y_receiver_if;
    logic        YREQ;
    logic        YACK;
    logic [31:0] YDATA;
    logic        YPARITY;

    modport master (output YREQ, output YDATA, output YPARITY, input YACK);
    modport slave  (input YREQ, input YDATA, input YPARITY, output YACK);
endinterface

// File: rtl/y_receiver.sv
// Y-side consumer: completes the 4-phase handshake, parity-checks each word and
// queues {perr, data} in a show-ahead FIFO drained by a simple pop interface.
module y_receiver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    y_receiver_if.slave            ych,
    input  logic                   PARTYSEL,
    input  logic                   RD_EN,
    output logic                   RD_VALID,
    output logic [31:0]            RD_DATA,
    output logic                   RD_PERR,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic [CNT_W-1:0]       PERR_CNT,
    input  logic                   PERR_CLR
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [32:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CNT_W-1:0] perr_cnt;
    logic            perr;
    logic            space;
    logic            push;
    logic            pop;

    // A full FIFO still has room when the head is popped in the same cycle.
    assign perr  = ^ych.YDATA ^ ych.YPARITY ^ PARTYSEL;
    assign pop   = RD_EN && (count != '0);
    assign space = (count < FULL_LVL) || RD_EN;
    assign push  = (state == IDLE) && ych.YREQ && space;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = ACK;
            ACK:     if (!ych.YREQ) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ych.YACK = (state == ACK);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the read port is masked while empty instead.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= {perr, ych.YDATA};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            perr_cnt <= '0;
        end else if (PERR_CLR) begin
            perr_cnt <= '0;
        end else if (push && perr && (perr_cnt != '1)) begin
            perr_cnt <= perr_cnt + 1'b1;
        end
    end

    always_comb begin
        RD_VALID          = (count != '0);
        {RD_PERR, RD_DATA} = RD_VALID ? mem[rd_ptr] : 33'd0;
        FULL              = (count == FULL_LVL);
        COUNT             = count;
        PERR_CNT          = perr_cnt;
    end

endmodule
